ram32x4s_fifo_ctrl: RTL and testbench

- Synchronous 32-deep x 4-bit FIFO controller that drives one RAM32X4S primitive and adds a one-entry registered output stage.
- The RAM has a single shared read/write address. The controller therefore arbitrates each cycle between a write (push) and a read fetch (pop into the output register).
- Sits between a 4-bit valid/ready producer and a 4-bit valid/ready consumer. Total capacity is 33 entries: 32 in the RAM plus 1 in the output register.

---
 rtl/ram32x4s_fifo_ctrl_if.sv | 27 ++
 rtl/ram32x4s_fifo_ctrl.sv | 89 ++++++++
 tb/tb_ram32x4s_fifo_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram32x4s_fifo_ctrl_if.sv
// Handshake and RAM-port bundle for the 33-entry RAM32X4S FIFO controller.
// The slave modport is the controller and the master modport is the surrounding producer, consumer and RAM.
interface ram32x4s_fifo_ctrl_if;
  logic       IN_VALID;
  logic [3:0] IN_DATA;
  logic       IN_READY;
  logic       OUT_VALID;
  logic [3:0] OUT_DATA;
  logic       OUT_READY;
  logic [4:0] A;
  logic [3:0] D;
  logic       WE;
  logic [3:0] O;
  logic [5:0] COUNT;
  logic       ALMOST_FULL;
  logic       ALMOST_EMPTY;

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY, O,
    output IN_READY, OUT_VALID, OUT_DATA, A, D, WE, COUNT, ALMOST_FULL, ALMOST_EMPTY
  );

  modport master (
    output IN_VALID, IN_DATA, OUT_READY, O,
    input  IN_READY, OUT_VALID, OUT_DATA, A, D, WE, COUNT, ALMOST_FULL, ALMOST_EMPTY
  );
endinterface

// File: rtl/ram32x4s_fifo_ctrl.sv
// 32x4 FIFO around one shared-address RAM32X4S plus a registered head entry (33 total).
// Push-to-OUT_VALID latency is 2 cycles; IN_READY drops at ram_cnt=32, and the head entry holds while OUT_READY=0.
module ram32x4s_fifo_ctrl #(
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 2
) (
  input  logic                 WCLK,
  input  logic                 CLR,
  ram32x4s_fifo_ctrl_if.slave  bus
);

  localparam logic [5:0] AF_TH   = 6'(AF_LEVEL);
  localparam logic [5:0] AE_TH   = 6'(AE_LEVEL);
  localparam logic [5:0] RAM_CAP = 6'd32;

  logic [4:0] wptr;
  logic [4:0] rptr;
  logic [5:0] ram_cnt;
  logic [5:0] ram_cnt_nxt;
  logic [5:0] count;
  logic       out_valid;
  logic       out_valid_nxt;
  logic [3:0] out_data;
  logic       last_grant;

  logic want_wr;
  logic want_rd;
  logic grant_wr;
  logic grant_rd;

  assign want_wr = bus.IN_VALID && (ram_cnt < RAM_CAP);
  assign want_rd = (ram_cnt != 6'd0) && (!out_valid || bus.OUT_READY);

  // Under contention the side that did not win last time gets the shared address.
  assign grant_wr = want_wr && (!want_rd || !last_grant);
  assign grant_rd = want_rd && (!want_wr ||  last_grant);

  assign bus.A        = grant_wr ? wptr : rptr;
  assign bus.D        = bus.IN_DATA;
  assign bus.WE       = grant_wr && !CLR;
  assign bus.IN_READY = grant_wr && !CLR;

  assign bus.OUT_VALID    = out_valid;
  assign bus.OUT_DATA     = out_data;
  assign bus.COUNT        = count;
  assign bus.ALMOST_FULL  = (count >= AF_TH);
  assign bus.ALMOST_EMPTY = (count <= AE_TH);

  always_comb begin
    ram_cnt_nxt   = ram_cnt;
    out_valid_nxt = out_valid;
    if (grant_wr) begin
      ram_cnt_nxt = ram_cnt + 6'd1;
    end else if (grant_rd) begin
      ram_cnt_nxt = ram_cnt - 6'd1;
    end
    if (grant_rd) begin
      out_valid_nxt = 1'b1;
    end else if (out_valid && bus.OUT_READY) begin
      out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge WCLK or posedge CLR) begin
    if (CLR) begin
      wptr       <= 5'd0;
      rptr       <= 5'd0;
      ram_cnt    <= 6'd0;
      count      <= 6'd0;
      out_valid  <= 1'b0;
      out_data   <= 4'd0;
      last_grant <= 1'b0;
    end else begin
      ram_cnt   <= ram_cnt_nxt;
      out_valid <= out_valid_nxt;
      count     <= ram_cnt_nxt + {5'd0, out_valid_nxt};
      if (grant_wr) begin
        wptr       <= wptr + 5'd1;
        last_grant <= 1'b1;
      end
      if (grant_rd) begin
        rptr       <= rptr + 5'd1;
        out_data   <= bus.O;
        last_grant <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ram32x4s_fifo_ctrl.sv
// Scoreboard bench for ram32x4s_fifo_ctrl with a behavioural RAM32X4S model.
module tb_ram32x4s_fifo_ctrl;

  logic WCLK = 1'b0;
  logic CLR  = 1'b1;

  ram32x4s_fifo_ctrl_if bus();

  ram32x4s_fifo_ctrl #(.AF_LEVEL(28), .AE_LEVEL(2)) dut (
    .WCLK (WCLK),
    .CLR  (CLR),
    .bus  (bus)
  );

  always #5 WCLK = ~WCLK;

  logic [3:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = 4'd0;
  always @(posedge WCLK) if (bus.WE) mem[bus.A] <= bus.D;
  assign bus.O = mem[bus.A];

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int mdl_cnt = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge WCLK);
    #1;
  endtask

  // Monitor: count and flags vs. model, then retire the pop and record the push of this cycle.
  always @(negedge WCLK) begin
    if (CLR) begin
      exp_q.delete();
      mdl_cnt = 0;
    end else begin
      chk("count", int'(bus.COUNT), mdl_cnt);
      chk("almost_full", int'(bus.ALMOST_FULL), int'(mdl_cnt >= 28));
      chk("almost_empty", int'(bus.ALMOST_EMPTY), int'(mdl_cnt <= 2));
      if (bus.OUT_VALID && bus.OUT_READY) begin
        pops++;
        mdl_cnt--;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_underflow: got data %0d, required no pop", bus.OUT_DATA);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          chk("out_data", int'(bus.OUT_DATA), int'(e));
        end
      end
      if (bus.IN_VALID && bus.IN_READY) begin
        exp_q.push_back(bus.IN_DATA);
        mdl_cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v, acc, af_at, ae_at, p0, n;
    logic prev_we;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = 4'd0;
    bus.OUT_READY = 1'b0;

    // 1: reset, mid-cycle CLR during a granted write
    repeat (3) cyc();
    CLR = 1'b0;
    cyc();
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = 4'd3;
    #1;
    chk("pre_clr_we", int'(bus.WE), 1);
    chk("pre_clr_in_ready", int'(bus.IN_READY), 1);
    #1;
    CLR = 1'b1;
    #1;
    chk("clr_we", int'(bus.WE), 0);
    chk("clr_in_ready", int'(bus.IN_READY), 0);
    cyc();
    cyc();
    CLR = 1'b0;
    bus.IN_VALID = 1'b0;
    #1;
    chk("rst_count", int'(bus.COUNT), 0);
    chk("rst_out_valid", int'(bus.OUT_VALID), 0);
    chk("rst_out_data", int'(bus.OUT_DATA), 0);
    chk("rst_a", int'(bus.A), 0);
    chk("rst_ae", int'(bus.ALMOST_EMPTY), 1);
    chk("rst_af", int'(bus.ALMOST_FULL), 0);

    // 2: single push of 0xA
    cyc();
    bus.IN_VALID  = 1'b1;
    bus.IN_DATA   = 4'hA;
    bus.OUT_READY = 1'b1;
    #1;
    chk("sp_c0_we", int'(bus.WE), 1);
    chk("sp_c0_a", int'(bus.A), 0);
    cyc();
    bus.IN_VALID = 1'b0;
    #1;
    chk("sp_c1_we", int'(bus.WE), 0);
    chk("sp_c1_a", int'(bus.A), 0);
    cyc();
    chk("sp_c2_out_valid", int'(bus.OUT_VALID), 1);
    chk("sp_c2_out_data", int'(bus.OUT_DATA), 10);
    cyc();
    chk("sp_c3_out_valid", int'(bus.OUT_VALID), 0);
    chk("sp_c3_count", int'(bus.COUNT), 0);

    // 3: fill with the consumer stalled
    bus.OUT_READY = 1'b0;
    v = 0; acc = 0; af_at = -1;
    for (int c = 0; c < 50; c++) begin
      cyc();
      bus.IN_VALID = (v < 40);
      bus.IN_DATA  = 4'(v);
      #1;
      if (bus.OUT_VALID) chk("fill_out_data", int'(bus.OUT_DATA), 0);
      if (bus.ALMOST_FULL && af_at < 0) af_at = int'(bus.COUNT);
      if (bus.IN_READY) begin
        v++;
        acc++;
      end
    end
    chk("fill_accepted", acc, 33);
    chk("fill_in_ready", int'(bus.IN_READY), 0);
    chk("fill_count", int'(bus.COUNT), 33);
    chk("fill_af_first", af_at, 28);
    chk("fill_af", int'(bus.ALMOST_FULL), 1);

    // 4: drain through the pointer wrap
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    p0 = pops; ae_at = -1;
    for (int c = 0; c < 60 && bus.COUNT != 6'd0; c++) begin
      cyc();
      if (bus.ALMOST_EMPTY && ae_at < 0) ae_at = int'(bus.COUNT);
    end
    chk("drain_pops", pops - p0, 33);
    chk("drain_count", int'(bus.COUNT), 0);
    chk("drain_ae_first", ae_at, 2);
    chk("drain_queue_empty", exp_q.size(), 0);

    // 5: continuous contention
    v = 0; acc = 0; n = 0; prev_we = 1'b0; p0 = pops;
    while (acc < 100 && n < 300) begin
      cyc();
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 4'(v);
      #1;
      if (n > 0) chk("we_alternate", int'(bus.WE), int'(!prev_we));
      prev_we = bus.WE;
      if (bus.IN_READY) begin
        v++;
        acc++;
      end
      n++;
    end
    cyc();
    bus.IN_VALID = 1'b0;
    for (int c = 0; c < 20 && bus.COUNT != 6'd0; c++) cyc();
    chk("cont_accepted", acc, 100);
    chk("cont_pops", pops - p0, 100);
    chk("cont_queue_empty", exp_q.size(), 0);

    // 6: backpressure with 0x5 parked at the head
    cyc();
    bus.IN_VALID  = 1'b1;
    bus.IN_DATA   = 4'h5;
    bus.OUT_READY = 1'b0;
    cyc();
    bus.IN_VALID = 1'b0;
    cyc();
    cyc();
    chk("bp_out_valid", int'(bus.OUT_VALID), 1);
    chk("bp_out_data", int'(bus.OUT_DATA), 5);
    for (int i = 0; i < 10; i++) begin
      cyc();
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 4'(6 + i);
      #1;
      chk("bp_in_ready", int'(bus.IN_READY), 1);
      chk("bp_we", int'(bus.WE), 1);
      chk("bp_hold", int'(bus.OUT_DATA), 5);
    end
    cyc();
    bus.IN_VALID = 1'b0;
    #1;
    chk("bp_final_data", int'(bus.OUT_DATA), 5);
    chk("bp_count", int'(bus.COUNT), 11);
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 30 && bus.COUNT != 6'd0; c++) cyc();
    cyc();
    chk("final_count", int'(bus.COUNT), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
